// File: rtl/evm_pkg.sv
// Shared types and defaults for the ballot tally bank.
// Session state encoding plus default sizing.
package evm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_CLOSED = 2'd2
  } session_t;

  localparam int DEF_NUM_CANDIDATES = 8;
  localparam int DEF_COUNT_WIDTH    = 8;

endpackage

// File: rtl/ballot_counter_cell.sv
// Saturating per-candidate vote counter.
// Holds at all-ones and raises a sticky sat flag on overflow attempts.
module ballot_counter_cell
  import evm_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   sat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc) begin
      if (&count) sat <= 1'b1;
      else        count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ballot_tally_bank.sv
// Session-gated ballot tally: edge-detected votes,
// per-candidate saturating counts and a saturating total.
module ballot_tally_bank
  import evm_pkg::*;
#(
  parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES,
  parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH,
  parameter int TOTAL_WIDTH    = 12
) (
  input  logic                      clk,
  input  logic                      initializer,
  input  logic                      session_open,
  input  logic                      session_close,
  input  logic                      session_clear,
  input  logic [3:0]                candidate_number,
  input  logic                      vote_cast,
  input  logic [3:0]                read_addr,
  output logic                      vote_accepted,
  output logic                      vote_rejected,
  output logic [COUNT_WIDTH-1:0]    read_count,
  output logic [TOTAL_WIDTH-1:0]    total_votes,
  output logic [NUM_CANDIDATES-1:0] saturated,
  output logic [1:0]                session_state
);

  localparam logic [4:0] NUM_C5 = 5'(NUM_CANDIDATES);

  session_t state;
  logic     vote_q;
  logic     evt;
  logic     in_open;
  logic     cand_ok;
  logic     total_full;
  logic     count_ok;
  logic     sel_full;
  logic     accept;
  logic     do_clear;

  logic [NUM_CANDIDATES-1:0] inc;
  logic [COUNT_WIDTH-1:0]    counts [NUM_CANDIDATES];

  assign evt        = vote_cast & ~vote_q;
  assign in_open    = (state == ST_OPEN);
  assign cand_ok    = {1'b0, candidate_number} < NUM_C5;
  assign total_full = &total_votes;
  assign count_ok   = evt & in_open & ~total_full;
  assign accept     = count_ok & cand_ok & ~sel_full;
  assign do_clear   = (state == ST_CLOSED) & session_clear;

  assign session_state = state;

  // Out-of-range indices match no cell, so they read 0 and count nothing.
  always_comb begin
    sel_full   = 1'b0;
    read_count = '0;
    inc        = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (candidate_number == 4'(i)) begin
        sel_full = &counts[i];
        inc[i]   = count_ok;
      end
      if (read_addr == 4'(i)) read_count = counts[i];
    end
  end

  for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_cell
    ballot_counter_cell #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_cell (
      .clk  (clk),
      .rst  (initializer),
      .inc  (inc[g]),
      .clear(do_clear),
      .count(counts[g]),
      .sat  (saturated[g])
    );
  end

  always_ff @(posedge clk or posedge initializer) begin
    if (initializer) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (session_open)  state <= ST_OPEN;
        ST_OPEN:   if (session_close) state <= ST_CLOSED;
        ST_CLOSED: if (session_clear) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // History resets high so a strobe held through reset release is ignored.
  always_ff @(posedge clk or posedge initializer) begin
    if (initializer) begin
      vote_q        <= 1'b1;
      vote_accepted <= 1'b0;
      vote_rejected <= 1'b0;
      total_votes   <= '0;
    end else begin
      vote_q        <= vote_cast;
      vote_accepted <= accept;
      vote_rejected <= evt & ~accept;
      if (do_clear)    total_votes <= '0;
      else if (accept) total_votes <= total_votes + TOTAL_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ballot_tally_bank.sv
// Bench for ballot_tally_bank: two instances (default and narrow
// counters) driven in lockstep and checked against an array model.
module tb_ballot_tally_bank;

  logic       clk = 1'b0;
  logic       initializer;
  logic       session_open;
  logic       session_close;
  logic       session_clear;
  logic [3:0] candidate_number;
  logic       vote_cast;
  logic [3:0] read_addr;

  logic        acc0, rej0, acc1, rej1;
  logic [7:0]  rc0;
  logic [3:0]  rc1;
  logic [11:0] tot0;
  logic [4:0]  tot1;
  logic [7:0]  sat0, sat1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  ballot_tally_bank u0 (
    .clk(clk), .initializer(initializer),
    .session_open(session_open), .session_close(session_close),
    .session_clear(session_clear), .candidate_number(candidate_number),
    .vote_cast(vote_cast), .read_addr(read_addr),
    .vote_accepted(acc0), .vote_rejected(rej0), .read_count(rc0),
    .total_votes(tot0), .saturated(sat0), .session_state(st0)
  );

  ballot_tally_bank #(.COUNT_WIDTH(4), .TOTAL_WIDTH(5)) u1 (
    .clk(clk), .initializer(initializer),
    .session_open(session_open), .session_close(session_close),
    .session_clear(session_clear), .candidate_number(candidate_number),
    .vote_cast(vote_cast), .read_addr(read_addr),
    .vote_accepted(acc1), .vote_rejected(rej1), .read_count(rc1),
    .total_votes(tot1), .saturated(sat1), .session_state(st1)
  );

  int mc   [2][16];
  int msat [2][16];
  int mt   [2];
  int mst  [2];
  int macc [2];
  int mrej [2];
  int mprev;
  int cmax [2] = '{255, 15};
  int tmax [2] = '{4095, 31};
  int acc_seen [2];
  int rej_seen [2];
  int total_n = 0;
  int bad_n   = 0;

  task automatic chk(input int k, input string name,
                     input int act, input int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL u%0d %s: got %0d want %0d", k, name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mc[k][i]   = 0;
        msat[k][i] = 0;
      end
      mt[k]   = 0;
      mst[k]  = 0;
      macc[k] = 0;
      mrej[k] = 0;
    end
    mprev = 1;
  endfunction

  // Next-edge prediction from the session rules.
  function automatic void model_step();
    bit evt;
    int c;
    evt = (vote_cast == 1'b1) && (mprev == 0);
    c = int'(candidate_number);
    for (int k = 0; k < 2; k++) begin
      macc[k] = 0;
      mrej[k] = 0;
      if (evt) begin
        if (mst[k] == 1 && c < 8 && mt[k] < tmax[k] && mc[k][c] < cmax[k]) begin
          mc[k][c]++;
          mt[k]++;
          macc[k] = 1;
        end else begin
          mrej[k] = 1;
          if (mst[k] == 1 && c < 8 && mt[k] < tmax[k])
            msat[k][c] = 1;
        end
      end
      if (mst[k] == 0 && session_open) mst[k] = 1;
      else if (mst[k] == 1 && session_close) mst[k] = 2;
      else if (mst[k] == 2 && session_clear) begin
        mst[k] = 0;
        mt[k]  = 0;
        for (int i = 0; i < 16; i++) begin
          mc[k][i]   = 0;
          msat[k][i] = 0;
        end
      end
    end
    mprev = vote_cast ? 1 : 0;
  endfunction

  initial begin
    model_reset();
    acc_seen = '{0, 0};
    rej_seen = '{0, 0};
    forever begin
      @(negedge clk);
      if (initializer) model_reset();
      for (int k = 0; k < 2; k++) begin
        int ra, exp_rc, exp_sat;
        int d_st, d_tot, d_rc, d_sat, d_acc, d_rej;
        d_st  = (k == 0) ? int'(st0)  : int'(st1);
        d_tot = (k == 0) ? int'(tot0) : int'(tot1);
        d_rc  = (k == 0) ? int'(rc0)  : int'(rc1);
        d_sat = (k == 0) ? int'(sat0) : int'(sat1);
        d_acc = (k == 0) ? int'(acc0) : int'(acc1);
        d_rej = (k == 0) ? int'(rej0) : int'(rej1);
        ra = int'(read_addr);
        exp_rc = (ra < 8) ? mc[k][ra] : 0;
        exp_sat = 0;
        for (int i = 0; i < 8; i++) exp_sat += msat[k][i] << i;
        chk(k, "state", d_st, mst[k]);
        chk(k, "total", d_tot, mt[k]);
        chk(k, "read_count", d_rc, exp_rc);
        chk(k, "saturated", d_sat, exp_sat);
        chk(k, "accepted", d_acc, macc[k]);
        chk(k, "rejected", d_rej, mrej[k]);
        chk(k, "pulse_excl", d_acc & d_rej, 0);
        acc_seen[k] += d_acc;
        rej_seen[k] += d_rej;
      end
      if (!initializer) model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    read_addr = read_addr + 4'd1;
  endtask

  task automatic vote(input logic [3:0] c);
    candidate_number = c;
    vote_cast = 1'b1;
    cyc();
    vote_cast = 1'b0;
    cyc();
  endtask

  task automatic open_session();
    session_open = 1'b1;
    cyc();
    session_open = 1'b0;
  endtask

  initial begin
    int p0;
    initializer      = 1'b1;
    session_open     = 1'b0;
    session_close    = 1'b0;
    session_clear    = 1'b0;
    candidate_number = 4'd0;
    vote_cast        = 1'b1;
    read_addr        = 4'd0;
    repeat (3) cyc();
    initializer = 1'b0;
    repeat (3) cyc();
    vote_cast = 1'b0;
    cyc();
    chk(0, "lit_no_pulse_after_reset", acc_seen[0] + rej_seen[0], 0);

    vote(4'd2);
    cyc();
    chk(0, "lit_idle_reject", rej_seen[0], 1);
    chk(0, "lit_idle_total", int'(tot0), 0);

    open_session();
    vote(4'd9);
    cyc();
    chk(0, "lit_oor_reject", rej_seen[0], 2);
    chk(0, "lit_open_state", int'(st0), 1);

    candidate_number = 4'd3;
    vote_cast = 1'b1;
    repeat (5) cyc();
    vote_cast = 1'b0;
    repeat (2) cyc();
    chk(0, "lit_held_one_accept", acc_seen[0], 1);
    chk(0, "lit_total_one", int'(tot0), 1);
    chk(0, "lit_model_c3", mc[0][3], 1);

    repeat (16) vote(4'd0);
    cyc();
    chk(1, "lit_sat0", int'(sat1[0]), 1);
    chk(1, "lit_total16", int'(tot1), 16);
    chk(1, "lit_model_c0", mc[1][0], 15);
    chk(1, "lit_16th_reject", rej_seen[1], 3);
    chk(0, "lit_total17", int'(tot0), 17);
    chk(0, "lit_nosat", int'(sat0), 0);

    repeat (15) vote(4'd1);
    vote(4'd2);
    cyc();
    chk(1, "lit_total_max", int'(tot1), 31);
    chk(1, "lit_totfull_nocount", mc[1][2], 0);
    chk(0, "lit_total33", int'(tot0), 33);

    candidate_number = 4'd5;
    vote_cast = 1'b1;
    session_close = 1'b1;
    cyc();
    vote_cast = 1'b0;
    session_close = 1'b0;
    cyc();
    chk(0, "lit_close_state", int'(st0), 2);
    chk(0, "lit_close_vote", mc[0][5], 1);
    chk(0, "lit_total34", int'(tot0), 34);
    vote(4'd4);
    cyc();
    chk(0, "lit_closed_total", int'(tot0), 34);

    session_clear = 1'b1;
    cyc();
    session_clear = 1'b0;
    chk(0, "lit_clear_state", int'(st0), 0);
    chk(0, "lit_clear_total", int'(tot0), 0);
    repeat (16) cyc();

    open_session();
    repeat (4) vote(4'd1);
    repeat (2) vote(4'd6);
    cyc();
    chk(0, "lit_total6", int'(tot0), 6);
    chk(0, "lit_model_c1", mc[0][1], 4);
    candidate_number = 4'd1;
    vote_cast = 1'b1;
    initializer = 1'b1;
    repeat (2) cyc();
    initializer = 1'b0;
    p0 = acc_seen[0] + rej_seen[0];
    repeat (4) cyc();
    chk(0, "lit_release_no_pulse", acc_seen[0] + rej_seen[0], p0);
    chk(0, "lit_reset_total", int'(tot0), 0);
    chk(0, "lit_reset_state", int'(st0), 0);
    vote_cast = 1'b0;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/ballot_tally_bank.md
BALLOT_TALLY_BANK -- requirements
Module: ballot_tally_bank

Interface
REQ-001 The module SHALL use parameter NUM_CANDIDATES, default 8, meaning the number of tallied candidates (legal range 2..16).
REQ-002 The module SHALL use parameter COUNT_WIDTH, default 8, meaning the width of each per-candidate count.
REQ-003 The module SHALL use parameter TOTAL_WIDTH, default 12, meaning the width of the all-candidate total.
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The module SHALL have the following ports:
  clk  input  1  clock; all state changes on the rising edge.
  initializer  input  1  reset; asynchronous, active-high.
  session_open  input  1  level; request IDLE->OPEN.
  session_close  input  1  level; request OPEN->CLOSED.
  session_clear  input  1  level; request CLOSED->IDLE and clear all counts.
  candidate_number  input  4  candidate index for this vote.
  vote_cast  input  1  vote strobe; level-held by the ballot unit.
  read_addr  input  4  candidate index for readout.
  vote_accepted  output  1  one-cycle pulse: vote counted.
  vote_rejected  output  1  one-cycle pulse: vote refused.
  read_count  output  COUNT_WIDTH  count of candidate read_addr.
  total_votes  output  TOTAL_WIDTH  sum of accepted votes.
  saturated  output  NUM_CANDIDATES  per-candidate sticky "count hit maximum" flag.
  session_state  output  2  encoded FSM state.

Function
REQ-006 The FSM SHALL have states IDLE=0, OPEN=1, CLOSED=2; encoding 3 is unreachable and SHALL recover to IDLE on the next edge.
REQ-007 IDLE SHALL go to OPEN on session_open; OPEN SHALL go to CLOSED on session_close; CLOSED SHALL go to IDLE on session_clear; all other inputs SHALL leave the state unchanged.
REQ-008 The ballot unit SHALL present a vote as a rising edge of vote_cast, detected against a registered copy of vote_cast; holding vote_cast high SHALL produce exactly one vote event.
REQ-009 A vote event in OPEN with candidate_number < NUM_CANDIDATES SHALL increment that candidate's count and total_votes on the same edge, and vote_accepted SHALL be high for the following cycle.
REQ-010 A vote event in IDLE or CLOSED, or with candidate_number >= NUM_CANDIDATES, SHALL change no count, and vote_rejected SHALL be high for the following cycle.
REQ-011 A vote event for a candidate whose count equals 2^COUNT_WIDTH-1 SHALL hold that count (no wrap), SHALL leave total_votes unchanged, SHALL set that candidate's saturated bit, and SHALL pulse vote_rejected.
REQ-012 total_votes SHALL saturate at 2^TOTAL_WIDTH-1; a vote arriving while total_votes is at that maximum SHALL be rejected and SHALL leave every count unchanged.
REQ-013 vote_accepted and vote_rejected SHALL never be high in the same cycle.
REQ-014 A vote event coinciding with session_close in OPEN SHALL still be counted; the state SHALL then become CLOSED.
REQ-015 read_count SHALL be combinational from the registered counts; read_addr >= NUM_CANDIDATES SHALL yield 0.
REQ-016 session_clear in CLOSED SHALL zero all counts, total_votes and saturated on the same edge as the state change to IDLE.

Reset
REQ-017 Asserting initializer SHALL immediately force state IDLE, all counts 0, total_votes 0, saturated 0, both pulses 0, and the vote_cast history register to 1, so that a vote_cast held high through reset release does not count.
REQ-018 Reset asserted mid-session SHALL discard the whole tally; no partial state SHALL survive reset.

Structure
REQ-019 The shared package evm_pkg SHALL hold the session state typedef and its encodings, plus the default values of NUM_CANDIDATES and COUNT_WIDTH.
REQ-020 Each candidate count SHALL be one instance of the sub-module ballot_counter_cell, a saturating counter with inputs inc and clear, outputs count and sat, and parameter COUNT_WIDTH, generated NUM_CANDIDATES times.

Verification
REQ-021 Reset, open, then one vote for candidate 3 with vote_cast held 5 cycles -> count[3]=1, total=1, exactly one vote_accepted pulse.
REQ-022 A vote for candidate 2 in IDLE, and a vote for candidate 9 in OPEN (NUM_CANDIDATES=8) -> vote_rejected pulses, all counts 0.
REQ-023 COUNT_WIDTH=4, 16 votes for candidate 0 -> count[0]=15, saturated[0]=1, 16th vote rejected, total=15.
REQ-024 A vote for candidate 5 on the same edge as session_close -> count[5]=1, state CLOSED; a further vote is rejected.
REQ-025 Counts {1:4, 6:2}, then initializer pulsed mid-session -> all zero, state IDLE, no pulse on release with vote_cast high.
REQ-026 In CLOSED with total=6, session_clear -> IDLE, total=0, read_count=0 for every read_addr.
